// File: rtl/spi_arbiter.sv
// Round-robin scheduler sharing one spi_core master between N_REQ single-word requesters.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts a stuck transfer after TIMEOUT cycles.
module spi_arbiter #(
  parameter int N_REQ   = 2,
  parameter int D_WIDTH = 8,
  parameter int ADDR_W  = 1,
  parameter int DIV_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]   req_tx_data,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [2*N_REQ-1:0]         req_mode,
  input  logic [DIV_W-1:0]           cfg_clk_div,
  output logic [N_REQ-1:0]           req_ack,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [D_WIDTH-1:0]         rsp_data,
  output logic                       rsp_err,
  output logic                       core_enable,
  output logic                       core_cpol,
  output logic                       core_cpha,
  output logic                       core_cont,
  output logic [ADDR_W-1:0]          core_addr,
  output logic [DIV_W-1:0]           core_clk_div,
  output logic [D_WIDTH-1:0]         core_tx_data,
  input  logic                       core_busy,
  input  logic [D_WIDTH-1:0]         core_rx_data
);

  // state       | meaning
  // S_IDLE      | arbitrate once the core reports not busy
  // S_LAUNCH    | one-cycle start strobe to the core
  // S_WAIT_BUSY | wait for the core to accept (busy rises)
  // S_WAIT_DONE | wait for the core to finish (busy falls)
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_win_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic               w_win_found;
  logic               w_grant;
  logic               w_launch;
  logic               w_done;
  logic               w_timeout;

  logic [N_REQ-1:0]   r_req_ack;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [D_WIDTH-1:0] r_rsp_data;
  logic               r_core_enable;
  logic               r_core_cpol;
  logic               r_core_cpha;
  logic [ADDR_W-1:0]  r_core_addr;
  logic [D_WIDTH-1:0] r_core_tx_data;

  // Walk downward in offset so the nearest requester at or after r_rr_ptr wins last.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (req_valid[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_ptr_nxt = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!core_busy && w_win_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_launch    = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (core_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!core_busy) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_idx          <= '0;
      r_req_ack      <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_core_enable  <= 1'b0;
      r_core_cpol    <= 1'b0;
      r_core_cpha    <= 1'b0;
      r_core_addr    <= '0;
      r_core_tx_data <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_ack     <= '0;
      r_rsp_valid   <= '0;
      r_core_enable <= w_launch;
      if (w_grant) begin
        r_idx                      <= w_win_idx;
        r_req_ack[w_win_idx]       <= 1'b1;
        r_core_tx_data             <= req_tx_data[int'(w_win_idx)*D_WIDTH +: D_WIDTH];
        r_core_addr                <= req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
        {r_core_cpol, r_core_cpha} <= req_mode[2*int'(w_win_idx) +: 2];
      end
      // A timed-out transfer still answers its requester, with zero data.
      if (w_done || w_timeout) begin
        r_rsp_valid[r_idx] <= 1'b1;
        r_rsp_data         <= w_done ? core_rx_data : '0;
        r_rr_ptr           <= w_ptr_nxt;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMR_W-1:0] r_timer;
  logic             r_rsp_err;

  // Loaded while launching so the count covers exactly TIMEOUT waiting cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_timeout;
      if (w_launch) begin
        r_timer <= TMR_W'(TIMEOUT - 1);
      end else if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign w_timeout = (r_state == S_WAIT_BUSY || (r_state == S_WAIT_DONE && core_busy))
                     && (r_timer == '0);
  assign rsp_err   = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign req_ack      = r_req_ack;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign core_enable  = r_core_enable;
  assign core_cpol    = r_core_cpol;
  assign core_cpha    = r_core_cpha;
  assign core_cont    = 1'b0;
  assign core_addr    = r_core_addr;
  assign core_clk_div = cfg_clk_div;
  assign core_tx_data = r_core_tx_data;

endmodule
